// File: rtl/fetch_unit.sv
// Front end of the out-of-order core: PC generation, single-outstanding
// instruction-memory read handshake, predictor redirect at response time,
// ROB flush redirect at any time, and a circular fetch queue toward decode.
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      FQ_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h60)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_mem_resp,
  input  logic [WIDTH-1:0]                 i_mem_rdata,
  output logic                             i_mem_read,
  output logic [WIDTH-1:0]                 i_mem_address,
  output logic [WIDTH/8-1:0]               i_mem_byte_enable,
  input  logic                             stall,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 flush_pc,
  output logic [WIDTH-1:0]                 fetch_pc,
  input  logic                             pred_taken,
  input  logic [WIDTH-1:0]                 pred_target,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_instr,
  output logic [WIDTH-1:0]                 out_pc,
  output logic                             out_pred_taken,
  output logic [WIDTH-1:0]                 out_pred_target,
  output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count,
  output logic                             fq_empty,
  output logic                             fq_full
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  // IDLE: nothing outstanding. WAIT: live request. DROP: request outstanding
  // but its response belongs to a flushed path and is thrown away.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  req_addr_q, req_addr_d;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next_c;

  logic [WIDTH-1:0]  instr_mem  [FQ_DEPTH];
  logic [WIDTH-1:0]  pc_mem     [FQ_DEPTH];
  logic [WIDTH-1:0]  target_mem [FQ_DEPTH];
  logic              taken_mem  [FQ_DEPTH];

  logic              enq_c;
  logic              deq_c;
  logic              issue_ok_c;
  logic [WIDTH-1:0]  seq_next_c;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Queue traffic this cycle and whether a slot remains for one more request.
  always_comb begin
    enq_c        = (state_q == ST_WAIT) && i_mem_resp && !flush;
    deq_c        = (count_q != '0) && out_ready && !flush;
    count_next_c = flush ? '0 : (count_q + CNT_W'(enq_c) - CNT_W'(deq_c));
    issue_ok_c   = !stall && (count_next_c < CNT_W'(FQ_DEPTH));
    seq_next_c   = pred_taken ? pred_target : (req_addr_q + WIDTH'(4));
  end

  // Fetch FSM next-state, next-PC and next-request-address selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        if (issue_ok_c) begin
          req_addr_d = flush ? flush_pc : pc_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mem_resp) begin
          if (flush) begin
            pc_d = flush_pc;
            if (issue_ok_c) begin
              req_addr_d = flush_pc;
              state_d    = ST_WAIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (issue_ok_c) begin
            // Back-to-back: next request goes out on the response cycle.
            req_addr_d = seq_next_c;
            state_d    = ST_WAIT;
          end else begin
            pc_d    = seq_next_c;
            state_d = ST_IDLE;
          end
        end else if (flush) begin
          // Address stays put; the memory transaction still completes.
          pc_d    = flush_pc;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        if (i_mem_resp) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_c) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (deq_c) begin
        head_q <= ptr_inc(head_q);
      end
      count_q <= count_next_c;
    end
  end

  // Queue payload storage; contents are only observed through the valid head.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      instr_mem[tail_q]  <= i_mem_rdata;
      pc_mem[tail_q]     <= req_addr_q;
      taken_mem[tail_q]  <= pred_taken;
      target_mem[tail_q] <= pred_target;
    end
  end

  // Memory side is a decode of the registered state and request address.
  assign i_mem_read        = (state_q != ST_IDLE);
  assign i_mem_address     = req_addr_q;
  assign fetch_pc          = req_addr_q;
  assign i_mem_byte_enable = '1;

  // Head payload is forced to zero while the queue is empty.
  assign fq_count        = count_q;
  assign fq_empty        = (count_q == '0);
  assign fq_full         = (count_q == CNT_W'(FQ_DEPTH));
  assign out_valid       = !fq_empty;
  assign out_instr       = out_valid ? instr_mem[head_q]  : '0;
  assign out_pc          = out_valid ? pc_mem[head_q]     : '0;
  assign out_pred_taken  = out_valid ? taken_mem[head_q]  : 1'b0;
  assign out_pred_target = out_valid ? target_mem[head_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model (expected queue contents,
// expected next fetch address, outstanding-request bookkeeping) checked every
// cycle, plus directed redirect/flush/full scenarios and a random phase.
module tb_fetch_unit;

  localparam int W     = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic            i_mem_resp;
  logic [W-1:0]    i_mem_rdata;
  logic            i_mem_read;
  logic [W-1:0]    i_mem_address;
  logic [W/8-1:0]  i_mem_byte_enable;
  logic            stall;
  logic            flush;
  logic [W-1:0]    flush_pc;
  logic [W-1:0]    fetch_pc;
  logic            pred_taken;
  logic [W-1:0]    pred_target;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_instr;
  logic [W-1:0]    out_pc;
  logic            out_pred_taken;
  logic [W-1:0]    out_pred_target;
  logic [CW-1:0]   fq_count;
  logic            fq_empty;
  logic            fq_full;

  fetch_unit #(
    .WIDTH    (W),
    .FQ_DEPTH (DEPTH),
    .RESET_PC (32'h60)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_mem_resp        (i_mem_resp),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_read        (i_mem_read),
    .i_mem_address     (i_mem_address),
    .i_mem_byte_enable (i_mem_byte_enable),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .fetch_pc          (fetch_pc),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .out_pred_taken    (out_pred_taken),
    .out_pred_target   (out_pred_target),
    .fq_count          (fq_count),
    .fq_empty          (fq_empty),
    .fq_full           (fq_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  // Model state: queue contents, outstanding request, next fetch address.
  ent_t        mq[$];
  logic        m_active;
  logic        m_poison;
  logic [31:0] m_req;
  logic [31:0] m_next;

  int n_checks;
  int n_pass;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h60) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_poison = 1'b0;
    m_req    = 32'h0;
    m_next   = 32'h60;
  endtask

  task automatic check_reset_outputs();
    check("rst_read",      32'(i_mem_read), 32'd0);
    check("rst_addr",      i_mem_address, 32'h0);
    check("rst_fetch_pc",  fetch_pc, 32'h0);
    check("rst_valid",     32'(out_valid), 32'd0);
    check("rst_count",     32'(fq_count), 32'd0);
    check("rst_full",      32'(fq_full), 32'd0);
    check("rst_instr",     out_instr, 32'h0);
    check("rst_out_pc",    out_pc, 32'h0);
    check("rst_pred",      32'(out_pred_taken), 32'd0);
    check("rst_target",    out_pred_target, 32'h0);
    check("rst_byte_en",   32'(i_mem_byte_enable), 32'hF);
  endtask

  // One clock: drive inputs, advance the model, clock, then compare.
  task automatic step(input logic resp, input logic fl, input logic [31:0] fpc,
                      input logic st, input logic rdy, input logic pt,
                      input logic [31:0] ptgt);
    logic        r;
    logic        enq;
    logic        deq;
    logic        ok;
    logic        issue;
    int          nc;
    logic [31:0] nxt;
    ent_t        e;
    r           = resp && m_active;
    i_mem_resp  = r;
    i_mem_rdata = r ? mem_word(m_req) : 32'hDEAD_BEEF;
    flush       = fl;
    flush_pc    = fpc;
    stall       = st;
    out_ready   = rdy;
    pred_taken  = pt;
    pred_target = ptgt;

    enq   = r && !m_poison && !fl;
    deq   = (mq.size() != 0) && rdy && !fl;
    nc    = fl ? 0 : (mq.size() + int'(enq) - int'(deq));
    ok    = !st && (nc < DEPTH);
    issue = ok && (!m_active || (r && !m_poison));
    nxt   = fl ? fpc : (enq ? (pt ? ptgt : m_req + 32'd4) : m_next);
    if (fl) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.pc    = m_req;
        e.instr = mem_word(m_req);
        e.pt    = pt;
        e.tgt   = ptgt;
        mq.push_back(e);
      end
    end
    if (issue) begin
      m_active = 1'b1;
      m_poison = 1'b0;
      m_req    = nxt;
    end else if (r) begin
      m_active = 1'b0;
    end else if (fl && m_active) begin
      m_poison = 1'b1;
    end
    m_next = nxt;

    @(posedge clk);
    #1;
    check("mem_read", 32'(i_mem_read), 32'(m_active));
    if (m_active) begin
      check("mem_addr", i_mem_address, m_req);
      check("fetch_pc", fetch_pc, m_req);
    end
    check("fq_count",  32'(fq_count),  32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("fq_empty",  32'(fq_empty),  32'(mq.size() == 0));
    check("fq_full",   32'(fq_full),   32'(mq.size() == DEPTH));
    if (mq.size() != 0) begin
      check("head_pc",     out_pc, mq[0].pc);
      check("head_instr",  out_instr, mq[0].instr);
      check("head_taken",  32'(out_pred_taken), 32'(mq[0].pt));
      check("head_target", out_pred_target, mq[0].tgt);
    end
  endtask

  // Respond to requests until a live request to addr is outstanding.
  task automatic run_to(input logic [31:0] addr);
    for (int i = 0; i < 20; i++) begin
      if (m_active && !m_poison && (m_req == addr)) break;
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    check("run_to_addr", i_mem_address, addr);
  endtask

  initial begin
    logic        r_resp;
    logic        r_fl;
    logic        r_st;
    logic        r_rdy;
    logic        r_pt;
    logic [31:0] r_fpc;
    logic [31:0] r_tgt;

    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    i_mem_resp  = 1'b0;
    i_mem_rdata = 32'h0;
    stall       = 1'b0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    out_ready   = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;

    // First request, first response, no bubble to the next request.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t1_first_req", i_mem_address, 32'h60);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_pc",    out_pc, 32'h60);
    check("t1_out_instr", out_instr, 32'h13);
    check("t1_next_req",  i_mem_address, 32'h64);
    check("t1_no_bubble", 32'(i_mem_read), 32'd1);

    // Fill with consumer blocked; one dequeue lets exactly one request out.
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_count", 32'(fq_count), 32'(DEPTH));
    check("t2_full",  32'(fq_full), 32'd1);
    check("t2_read",  32'(i_mem_read), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t2_reissue", 32'(i_mem_read), 32'd1);
    check("t2_req_addr", i_mem_address, 32'h6C);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_refull_count", 32'(fq_count), 32'(DEPTH));
    check("t2_refull_read",  32'(i_mem_read), 32'd0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Predictor redirect at response time.
    step(1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0);
    run_to(32'h80);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    check("t3_target_req",  i_mem_address, 32'h200);
    check("t3_head_pc",     out_pc, 32'h80);
    check("t3_head_taken",  32'(out_pred_taken), 32'd1);
    check("t3_head_target", out_pred_target, 32'h200);

    // Flush while a request is outstanding: address held, response dropped.
    step(1'b0, 1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h0);
    run_to(32'h60);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_req", i_mem_address, 32'h64);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_hold1", i_mem_address, 32'h64);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_hold2", i_mem_address, 32'h64);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_count", 32'(fq_count), 32'd0);
    check("t4_idle",  32'(i_mem_read), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t4_restart", i_mem_address, 32'h400);

    // Flush + response + dequeue together, then repeated flush while dropping.
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t5_pre_count", 32'(fq_count), 32'd2);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t5_count",   32'(fq_count), 32'd0);
    check("t5_valid",   32'(out_valid), 32'd0);
    check("t5_restart", i_mem_address, 32'h300);
    step(1'b0, 1'b1, 32'h480, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t5_drop_idle", 32'(i_mem_read), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t5_latest_flush", i_mem_address, 32'h500);

    // Random traffic: sequential-only first, then with flushes and predictions.
    for (int i = 0; i < 700; i++) begin
      r_resp = ($urandom_range(0, 2) != 0);
      r_rdy  = ($urandom_range(0, 1) != 0);
      r_st   = ($urandom_range(0, 3) == 0);
      r_fl   = (i >= 300) && ($urandom_range(0, 39) == 0);
      r_pt   = (i >= 300) && ($urandom_range(0, 7) == 0);
      r_fpc  = {$urandom_range(0, 32'hFFFF) * 32'd4};
      r_tgt  = {$urandom_range(0, 32'hFFFF) * 32'd4};
      step(r_resp, r_fl, r_fpc, r_st, r_rdy, r_pt, r_tgt);
    end

    // Asynchronous reset in the middle of an outstanding request.
    for (int k = 0; k < 10; k++) begin
      if (m_active) break;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    check("mid_rst_active", 32'(i_mem_read), 32'd1);
    i_mem_resp  = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    flush       = 1'b0;
    rst         = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst        = 1'b1;
    i_mem_resp = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_req",   i_mem_address, 32'h60);
    check("post_rst_count", 32'(fq_count), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post_rst_head", out_pc, 32'h60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
